// File: rtl/mips32_alu_arbiter.sv
// mips32_alu_arbiter: round-robin front end that shares one combinational
// MIPS32 ALU between two requesters. S1 holds the decoded operation and
// drives the ALU; S2 captures the ALU result for the response port.
// Optional build macro ALU_ARB_PERF_EN adds saturating performance counters.

module mips32_alu_ctrl (
  input  logic [3:0] alu_op_i,
  output logic [2:0] alu_ctr_o,
  output logic       illegal_o
);
  // ALU_op -> ALU_ctr decode; 1100 and 1101 are unassigned and flagged illegal
  always_comb begin
    alu_ctr_o = 3'b000;
    illegal_o = 1'b0;
    case (alu_op_i)
      4'b0000: alu_ctr_o = 3'b000; // and
      4'b0001: alu_ctr_o = 3'b001; // or
      4'b0010: alu_ctr_o = 3'b010; // add
      4'b0011: alu_ctr_o = 3'b011; // xor
      4'b0100: alu_ctr_o = 3'b100; // sub
      4'b0101: alu_ctr_o = 3'b101; // sltu
      4'b0110: alu_ctr_o = 3'b110; // nor
      4'b0111: alu_ctr_o = 3'b111; // slt
      4'b1000: alu_ctr_o = 3'b010; // addi
      4'b1001: alu_ctr_o = 3'b100; // subi
      4'b1010: alu_ctr_o = 3'b111; // slti
      4'b1011: alu_ctr_o = 3'b101; // sltiu
      4'b1110: alu_ctr_o = 3'b000; // andi
      4'b1111: alu_ctr_o = 3'b001; // ori
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

module mips32_alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [ID_W-1:0]   req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [ID_W-1:0]   req1_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [ID_W-1:0]   rsp_tag,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_err
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_req0_cnt,
  output logic [15:0]       perf_req1_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  logic              grant0, grant1, s1_adv, s1_free, accept;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [ID_W-1:0]   sel_tag;
  logic [2:0]        dec_ctr;
  logic              dec_illegal;

  logic              last_grant_q, last_grant_d;
  logic              s1_valid_q, s1_valid_d, s1_err_q, s1_err_d, s1_src_q, s1_src_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]        s1_ctr_q, s1_ctr_d;
  logic [ID_W-1:0]   s1_tag_q, s1_tag_d;
  logic              s2_valid_q, s2_valid_d, s2_src_q, s2_src_d;
  logic              s2_zero_q, s2_zero_d, s2_ovf_q, s2_ovf_d, s2_err_q, s2_err_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic [ID_W-1:0]   s2_tag_q, s2_tag_d;

  // Round-robin grant and handshake; readys are held low while in reset
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    s1_adv     = ~s2_valid_q | rsp_ready;
    s1_free    = ~s1_valid_q | s1_adv;
    req0_ready = rst_n & s1_free & grant0;
    req1_ready = rst_n & s1_free & grant1;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    sel_op     = grant1 ? req1_op  : req0_op;
    sel_a      = grant1 ? req1_a   : req0_a;
    sel_b      = grant1 ? req1_b   : req0_b;
    sel_tag    = grant1 ? req1_tag : req0_tag;
  end

  mips32_alu_ctrl u_ctrl (
    .alu_op_i  (sel_op),
    .alu_ctr_o (dec_ctr),
    .illegal_o (dec_illegal)
  );

  // Pipeline next state: S2 drain/refill, S1 advance, then new accept
  always_comb begin
    last_grant_d = last_grant_q;
    s1_valid_d   = s1_valid_q;
    s1_err_d     = s1_err_q;
    s1_src_d     = s1_src_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_ctr_d     = s1_ctr_q;
    s1_tag_d     = s1_tag_q;
    s2_valid_d   = s2_valid_q;
    s2_src_d     = s2_src_q;
    s2_zero_d    = s2_zero_q;
    s2_ovf_d     = s2_ovf_q;
    s2_err_d     = s2_err_q;
    s2_result_d  = s2_result_q;
    s2_tag_d     = s2_tag_q;
    if (s1_valid_q & s1_adv) begin
      s2_valid_d  = 1'b1;
      s2_src_d    = s1_src_q;
      s2_tag_d    = s1_tag_q;
      s2_err_d    = s1_err_q;
      s2_result_d = s1_err_q ? '0 : alu_result;
      s2_zero_d   = ~s1_err_q & alu_zero;
      s2_ovf_d    = ~s1_err_q & alu_overflow;
    end else if (s2_valid_q & rsp_ready) begin
      s2_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      // Illegal ops park the ALU on zero operands so it sees a quiet input
      s1_valid_d   = 1'b1;
      s1_err_d     = dec_illegal;
      s1_src_d     = grant1;
      s1_tag_d     = sel_tag;
      s1_a_d       = dec_illegal ? '0 : sel_a;
      s1_b_d       = dec_illegal ? '0 : sel_b;
      s1_ctr_d     = dec_illegal ? 3'b000 : dec_ctr;
      last_grant_d = grant1;
    end
  end

  // State registers; last_grant resets to 1 so req0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_src_q     <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_ctr_q     <= 3'b000;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_src_q     <= 1'b0;
      s2_zero_q    <= 1'b0;
      s2_ovf_q     <= 1'b0;
      s2_err_q     <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s1_src_q     <= s1_src_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_ctr_q     <= s1_ctr_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_src_q     <= s2_src_d;
      s2_zero_q    <= s2_zero_d;
      s2_ovf_q     <= s2_ovf_d;
      s2_err_q     <= s2_err_d;
      s2_result_q  <= s2_result_d;
      s2_tag_q     <= s2_tag_d;
    end
  end

  assign alu_a        = s1_a_q;
  assign alu_b        = s1_b_q;
  assign alu_ctr      = s1_ctr_q;
  assign rsp_valid    = s2_valid_q;
  assign rsp_src      = s2_src_q;
  assign rsp_tag      = s2_tag_q;
  assign rsp_result   = s2_result_q;
  assign rsp_zero     = s2_zero_q;
  assign rsp_overflow = s2_ovf_q;
  assign rsp_err      = s2_err_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf0_q, perf0_d, perf1_q, perf1_d, perf_stall_q, perf_stall_d;

  // Saturating counters: accepts per requester and offered-but-stalled cycles
  always_comb begin
    perf0_d      = perf0_q;
    perf1_d      = perf1_q;
    perf_stall_d = perf_stall_q;
    if (req0_valid & req0_ready & (perf0_q != 16'hFFFF)) perf0_d = perf0_q + 16'd1;
    if (req1_valid & req1_ready & (perf1_q != 16'hFFFF)) perf1_d = perf1_q + 16'd1;
    if ((req0_valid | req1_valid) & ~accept & (perf_stall_q != 16'hFFFF))
      perf_stall_d = perf_stall_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf0_q      <= '0;
      perf1_q      <= '0;
      perf_stall_q <= '0;
    end else begin
      perf0_q      <= perf0_d;
      perf1_q      <= perf1_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_req0_cnt  = perf0_q;
  assign perf_req1_cnt  = perf1_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_mips32_alu_arbiter.sv
// Testbench for mips32_alu_arbiter: behavioural ALU stub plus a
// transaction-level model of the two pipeline slots and arbitration rules.
module tb_mips32_alu_arbiter;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [IW-1:0] req0_tag, req1_tag;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [2:0]    alu_ctr;
  logic          alu_zero, alu_overflow;
  logic          rsp_valid, rsp_ready, rsp_src, rsp_zero, rsp_overflow, rsp_err;
  logic [IW-1:0] rsp_tag;
  logic [DW-1:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
  logic [15:0]   perf_req0_cnt, perf_req1_cnt, perf_stall_cnt;
`endif

  mips32_alu_arbiter #(.DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
`ifdef ALU_ARB_PERF_EN
    , .perf_req0_cnt(perf_req0_cnt), .perf_req1_cnt(perf_req1_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures;

  // ---------------- ALU behaviour (shared by stub and reference) ----------
  function automatic logic [DW-1:0] alu_fn(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a ^ b;
      3'b100:  return a - b;
      3'b101:  return (a < b) ? 32'd1 : 32'd0;
      3'b110:  return ~(a | b);
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic alu_ovf(input logic [2:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    if (c == 3'b010) begin s = a + b; return (a[31] == b[31]) && (s[31] != a[31]); end
    if (c == 3'b100) begin s = a - b; return (a[31] != b[31]) && (s[31] != a[31]); end
    return 1'b0;
  endfunction

  always_comb begin
    alu_result   = alu_fn(alu_ctr, alu_a, alu_b);
    alu_zero     = (alu_result == '0);
    alu_overflow = alu_ovf(alu_ctr, alu_a, alu_b);
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [IW-1:0] tag;
    logic          src;
  } txn_t;

  txn_t m_s1, m_s2;
  bit   m_s1f, m_s2f, m_last;
  bit   e_r0, e_r1;
  int   m_cnt0, m_cnt1, m_stall;

  function automatic bit is_ill(input logic [3:0] op);
    return (op == 4'b1100) || (op == 4'b1101);
  endfunction

  function automatic logic [2:0] ctr_of(input logic [3:0] op);
    case (op)
      4'd0: return 3'd0;  4'd1: return 3'd1;  4'd2: return 3'd2;  4'd3: return 3'd3;
      4'd4: return 3'd4;  4'd5: return 3'd5;  4'd6: return 3'd6;  4'd7: return 3'd7;
      4'd8: return 3'd2;  4'd9: return 3'd4;  4'd10: return 3'd7; 4'd11: return 3'd5;
      4'd14: return 3'd0; default: return 3'd1;
    endcase
  endfunction

  // {src, tag, result, zero, overflow, err}
  function automatic logic [39:0] exp_rsp(input txn_t t);
    logic [DW-1:0] r;
    if (is_ill(t.op)) return {t.src, t.tag, 32'h0, 1'b0, 1'b0, 1'b1};
    r = alu_fn(ctr_of(t.op), t.a, t.b);
    return {t.src, t.tag, r, (r == 32'h0), alu_ovf(ctr_of(t.op), t.a, t.b), 1'b0};
  endfunction

  // {alu_a, alu_b, alu_ctr}
  function automatic logic [66:0] exp_alu(input txn_t t);
    if (is_ill(t.op)) return 67'h0;
    return {t.a, t.b, ctr_of(t.op)};
  endfunction

  function automatic void model_reset();
    m_s1f = 0; m_s2f = 0; m_last = 1'b1;
    m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
  endfunction

  function automatic void model_eval();
    bit adv, free, g0, g1;
    adv  = !m_s2f || (rsp_ready === 1'b1);
    free = !m_s1f || adv;
    g0   = req0_valid && (!req1_valid || m_last);
    g1   = req1_valid && (!req0_valid || !m_last);
    e_r0 = free && g0;
    e_r1 = free && g1;
  endfunction

  function automatic void model_commit();
    bit adv;
    txn_t t;
    adv = !m_s2f || (rsp_ready === 1'b1);
    if ((req0_valid || req1_valid) && !(e_r0 || e_r1)) m_stall++;
    if (m_s1f && adv) begin m_s2 = m_s1; m_s2f = 1; m_s1f = 0; end
    else if (m_s2f && rsp_ready) m_s2f = 0;
    if (e_r0 || e_r1) begin
      if (e_r0) begin t = '{op: req0_op, a: req0_a, b: req0_b, tag: req0_tag, src: 1'b0}; m_cnt0++; end
      else      begin t = '{op: req1_op, a: req1_a, b: req1_b, tag: req1_tag, src: 1'b1}; m_cnt1++; end
      m_s1 = t; m_s1f = 1; m_last = t.src;
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic new_req(input int idx, input bit legal, input logic [IW-1:0] tag);
    logic [3:0] op;
    logic [DW-1:0] a, b;
    op = 4'($urandom_range(15, 0));
    while (legal && is_ill(op)) op = 4'($urandom_range(15, 0));
    a = $urandom;
    b = ($urandom_range(3, 0) == 0) ? a : $urandom;
    if (idx == 0) begin req0_op = op; req0_a = a; req0_b = b; req0_tag = tag; req0_valid = 1'b1; end
    else          begin req1_op = op; req1_a = a; req1_b = b; req1_tag = tag; req1_valid = 1'b1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++;
      $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if ({alu_a, alu_b, alu_ctr} !== 67'h0) begin failures++;
      $display("FAIL reset_alu got=%h exp=0", {alu_a, alu_b, alu_ctr}); end
    checks++; if ({rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== 41'h0) begin failures++;
      $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1; req1_valid = 1'b0;
    req0_op = 4'b0100; req0_a = 32'h0000_00F0; req0_b = 32'h0000_0F00; req0_tag = 4'd3; req0_valid = 1'b1;
    sample();
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++;
      $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    advance();
    req0_valid = 1'b0;
    sample();
    checks++; if ({alu_a, alu_b, alu_ctr} !== {32'h0000_00F0, 32'h0000_0F00, 3'b100}) begin failures++;
      $display("FAIL single_s1_alu got=%h exp=%h", {alu_a, alu_b, alu_ctr}, {32'h0000_00F0, 32'h0000_0F00, 3'b100}); end
    checks++; if (rsp_valid !== 1'b0) begin failures++;
      $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    advance();
    sample();
    checks++; if (rsp_valid !== 1'b1) begin failures++;
      $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if ({rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== {1'b0, 4'd3, 32'hFFFF_F1F0, 3'b000}) begin failures++;
      $display("FAIL single_rsp got=%h exp=%h", {rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}, {1'b0, 4'd3, 32'hFFFF_F1F0, 3'b000}); end
    advance();
    sample();
    checks++; if (rsp_valid !== 1'b0) begin failures++;
      $display("FAIL single_rsp_clear got=%b exp=0", rsp_valid); end
    advance();
  endtask

  task automatic test_alternate();
    int n_rsp;
    bit a0, a1;
    do_reset();
    rsp_ready = 1'b1;
    n_rsp = 0;
    new_req(0, 1'b1, 4'd0);
    new_req(1, 1'b1, 4'd1);
    for (int c = 0; c < 10; c++) begin
      if (c >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      sample();
      if (c < 6) begin
        checks++; if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin failures++;
          $display("FAIL alt_grant cyc=%0d got=%b exp=%b", c, {req0_ready, req1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01); end
      end
      if (rsp_valid === 1'b1) begin
        checks++; if ({rsp_src, rsp_tag} !== {1'(n_rsp % 2), 4'(n_rsp)}) begin failures++;
          $display("FAIL alt_order got=%h exp=%h", {rsp_src, rsp_tag}, {1'(n_rsp % 2), 4'(n_rsp)}); end
        checks++; if (!m_s2f || {rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== exp_rsp(m_s2)) begin failures++;
          $display("FAIL alt_rsp got=%h exp=%h", {rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}, exp_rsp(m_s2)); end
        n_rsp++;
      end
      a0 = e_r0; a1 = e_r1;
      advance();
      if (a0) new_req(0, 1'b1, req0_tag + 4'd2);
      if (a1) new_req(1, 1'b1, req1_tag + 4'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (n_rsp != 6) begin failures++;
      $display("FAIL alt_count got=%0d exp=6", n_rsp); end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1; req0_valid = 1'b0;
    req1_op = 4'b1101; req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_tag = 4'd5; req1_valid = 1'b1;
    sample();
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++;
      $display("FAIL ill_ready got=%b exp=01", {req0_ready, req1_ready}); end
    advance();
    req1_valid = 1'b0;
    sample();
    checks++; if ({alu_a, alu_b, alu_ctr} !== 67'h0) begin failures++;
      $display("FAIL ill_alu got=%h exp=0", {alu_a, alu_b, alu_ctr}); end
    advance();
    sample();
    checks++; if ({rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== {1'b1, 1'b1, 4'd5, 32'h0, 3'b001}) begin failures++;
      $display("FAIL ill_rsp got=%h exp=%h", {rsp_valid, rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}, {1'b1, 1'b1, 4'd5, 32'h0, 3'b001}); end
    advance();
  endtask

  task automatic test_stall();
    int n_pop;
    bit a0;
    rsp_ready = 1'b0; req1_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      new_req(0, 1'b1, 4'(k));
      sample();
      checks++; if (req0_ready !== 1'b1) begin failures++;
        $display("FAIL stall_fill%0d got=%b exp=1", k, req0_ready); end
      advance();
    end
    new_req(0, 1'b1, 4'd3);
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b001) begin failures++;
        $display("FAIL stall_hs cyc=%0d got=%b exp=001", c, {req0_ready, req1_ready, rsp_valid}); end
      checks++; if ({rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== exp_rsp(m_s2) || rsp_tag !== 4'd1) begin failures++;
        $display("FAIL stall_rsp cyc=%0d got=%h exp=%h", c, {rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}, exp_rsp(m_s2)); end
      checks++; if ({alu_a, alu_b, alu_ctr} !== exp_alu(m_s1)) begin failures++;
        $display("FAIL stall_alu cyc=%0d got=%h exp=%h", c, {alu_a, alu_b, alu_ctr}, exp_alu(m_s1)); end
      advance();
    end
    rsp_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++; if (req0_ready !== e_r0) begin failures++;
        $display("FAIL drain_ready cyc=%0d got=%b exp=%b", c, req0_ready, e_r0); end
      if (rsp_valid === 1'b1) begin
        n_pop++;
        checks++; if (rsp_tag !== 4'(n_pop)) begin failures++;
          $display("FAIL drain_order got=%0d exp=%0d", rsp_tag, n_pop); end
      end
      a0 = e_r0;
      advance();
      if (a0) req0_valid = 1'b0;
    end
    checks++; if (n_pop != 3) begin failures++;
      $display("FAIL drain_count got=%0d exp=3", n_pop); end
  endtask

  task automatic test_async_reset();
    int n_pop;
    rsp_ready = 1'b0; req1_valid = 1'b0;
    new_req(0, 1'b1, 4'd7); sample(); advance();
    new_req(0, 1'b1, 4'd8); sample(); advance();
    new_req(0, 1'b1, 4'd9);
    new_req(1, 1'b1, 4'd10);
    sample();
    checks++; if (rsp_valid !== 1'b1) begin failures++;
      $display("FAIL arst_full got=%b exp=1", rsp_valid); end
    #2;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin failures++;
      $display("FAIL arst_hs got=%b exp=000", {rsp_valid, req0_ready, req1_ready}); end
    checks++; if ({alu_a, alu_b, alu_ctr} !== 67'h0) begin failures++;
      $display("FAIL arst_alu got=%h exp=0", {alu_a, alu_b, alu_ctr}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    sample();
    checks++; if ({req0_ready, req1_ready, rsp_valid} !== 3'b100) begin failures++;
      $display("FAIL arst_first_grant got=%b exp=100", {req0_ready, req1_ready, rsp_valid}); end
    advance();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_pop = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      if (rsp_valid === 1'b1) begin
        n_pop++;
        checks++; if ({rsp_src, rsp_tag} !== {1'b0, 4'd9}) begin failures++;
          $display("FAIL arst_rsp got=%h exp=%h", {rsp_src, rsp_tag}, {1'b0, 4'd9}); end
      end
      advance();
    end
    checks++; if (n_pop != 1) begin failures++;
      $display("FAIL arst_count got=%0d exp=1", n_pop); end
  endtask

  task automatic test_random();
    bit a0, a1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c < 390) begin
        if (!req0_valid && $urandom_range(1, 0) == 1) new_req(0, 1'b0, 4'($urandom));
        else if (req0_valid && $urandom_range(15, 0) == 0) req0_valid = 1'b0;
        if (!req1_valid && $urandom_range(1, 0) == 1) new_req(1, 1'b0, 4'($urandom));
        else if (req1_valid && $urandom_range(15, 0) == 0) req1_valid = 1'b0;
        rsp_ready = ($urandom_range(3, 0) != 0);
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      end
      sample();
      checks++; if ({req0_ready, req1_ready, rsp_valid} !== {e_r0, e_r1, m_s2f}) begin failures++;
        $display("FAIL rnd_hs cyc=%0d got=%b exp=%b", c, {req0_ready, req1_ready, rsp_valid}, {e_r0, e_r1, m_s2f}); end
      if (m_s2f) begin
        checks++; if ({rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err} !== exp_rsp(m_s2)) begin failures++;
          $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", c, {rsp_src, rsp_tag, rsp_result, rsp_zero, rsp_overflow, rsp_err}, exp_rsp(m_s2)); end
      end
      if (m_s1f) begin
        checks++; if ({alu_a, alu_b, alu_ctr} !== exp_alu(m_s1)) begin failures++;
          $display("FAIL rnd_alu cyc=%0d got=%h exp=%h", c, {alu_a, alu_b, alu_ctr}, exp_alu(m_s1)); end
      end
      a0 = e_r0; a1 = e_r1;
      advance();
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
`ifdef ALU_ARB_PERF_EN
    sample();
    checks++; if ({perf_req0_cnt, perf_req1_cnt, perf_stall_cnt} !== {16'(m_cnt0), 16'(m_cnt1), 16'(m_stall)}) begin failures++;
      $display("FAIL rnd_perf got=%0d,%0d,%0d exp=%0d,%0d,%0d", perf_req0_cnt, perf_req1_cnt, perf_stall_cnt, m_cnt0, m_cnt1, m_stall); end
    advance();
`endif
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    bit a0, a1;
    do_reset();
    rsp_ready = 1'b0; req1_valid = 1'b0;
    new_req(0, 1'b1, 4'd1);
    for (int c = 0; c < 9; c++) begin
      if (c == 6) rsp_ready = 1'b1;
      sample();
      a0 = e_r0; a1 = e_r1;
      advance();
      if (a0) begin
        if (c < 6) new_req(0, 1'b1, 4'(c + 2));
        else begin req0_valid = 1'b0; new_req(1, 1'b1, 4'd11); end
      end
      if (a1) new_req(1, 1'b1, 4'd12);
      if (c == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    sample();
    checks++; if ({perf_req0_cnt, perf_req1_cnt, perf_stall_cnt} !== {16'd3, 16'd2, 16'd4}) begin failures++;
      $display("FAIL perf_counts got=%0d,%0d,%0d exp=3,2,4", perf_req0_cnt, perf_req1_cnt, perf_stall_cnt); end
    advance();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_illegal();
    test_stall();
    test_async_reset();
    test_random();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
